// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one fixed 16-entry 12-bit sprite palette between
// N_REQ pixel requesters; two-stage lookup pipeline returns tagged RGB results.
module palette_lookup_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 3,
  parameter int KEY_INDEX = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*4-1:0]   req_index,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_red,
  output logic [3:0]           rsp_green,
  output logic [3:0]           rsp_blue,
  output logic                 rsp_transparent,
  output logic                 busy
);

  localparam int NE = 1 << ID_W;

  function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
    case (idx)
      4'd0:    palette_rgb = 12'hF0D;
      4'd1:    palette_rgb = 12'h302;
      4'd2:    palette_rgb = 12'hA00;
      4'd3:    palette_rgb = 12'hA09;
      4'd4:    palette_rgb = 12'hBBB;
      4'd5:    palette_rgb = 12'h500;
      4'd6:    palette_rgb = 12'h776;
      4'd7:    palette_rgb = 12'h000;
      4'd8:    palette_rgb = 12'h504;
      4'd9:    palette_rgb = 12'hD0B;
      4'd10:   palette_rgb = 12'h200;
      4'd11:   palette_rgb = 12'h862;
      4'd12:   palette_rgb = 12'h432;
      4'd13:   palette_rgb = 12'h700;
      4'd14:   palette_rgb = 12'hC20;
      default: palette_rgb = 12'h807;
    endcase
  endfunction

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NE-1:0]   vld_ext;
  logic            found;
  logic [ID_W-1:0] grant_id;
  logic [3:0]      grant_idx;
  int              cand_i;

  logic            vld_p1_q, vld_p1_d;
  logic [ID_W-1:0] id_p1_q, id_p1_d;
  logic [3:0]      idx_p1_q, idx_p1_d;

  logic            vld_p2_q, vld_p2_d;
  logic [ID_W-1:0] id_p2_q, id_p2_d;
  logic [11:0]     rgb_p2_q, rgb_p2_d;
  logic            key_p2_q, key_p2_d;

  // Search starts at rr_ptr and wraps modulo N_REQ; reset blocks every grant.
  always_comb begin
    vld_ext  = NE'(req_valid);
    found    = 1'b0;
    grant_id = '0;
    cand_i   = 0;
    if (!Reset) begin
      for (int off = 0; off < N_REQ; off++) begin
        cand_i = int'(rr_ptr_q) + off;
        if (cand_i >= N_REQ) cand_i = cand_i - N_REQ;
        if (!found && vld_ext[ID_W'(cand_i)]) begin
          found    = 1'b1;
          grant_id = ID_W'(cand_i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        req_ready[i] = found;
        grant_idx    = req_index[4*i +: 4];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
    // p0 -> p1: capture the granted request
    vld_p1_d = found;
    id_p1_d  = grant_id;
    idx_p1_d = grant_idx;
    // p1 -> p2: palette read; result fields hold while no lookup completes
    vld_p2_d = vld_p1_q;
    id_p2_d  = id_p2_q;
    rgb_p2_d = rgb_p2_q;
    key_p2_d = key_p2_q;
    if (vld_p1_q) begin
      id_p2_d  = id_p1_q;
      rgb_p2_d = palette_rgb(idx_p1_q);
      key_p2_d = (idx_p1_q == 4'(KEY_INDEX));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_q <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      id_p2_q  <= '0;
      rgb_p2_q <= '0;
      key_p2_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      id_p2_q  <= id_p2_d;
      rgb_p2_q <= rgb_p2_d;
      key_p2_q <= key_p2_d;
    end
    id_p1_q  <= id_p1_d;
    idx_p1_q <= idx_p1_d;
  end

  assign rsp_valid       = vld_p2_q;
  assign rsp_id          = id_p2_q;
  assign rsp_red         = rgb_p2_q[11:8];
  assign rsp_green       = rgb_p2_q[7:4];
  assign rsp_blue        = rgb_p2_q[3:0];
  assign rsp_transparent = key_p2_q;
  assign busy            = vld_p1_q | vld_p2_q;

endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
- Shares one 16-entry, 12-bit sprite colour palette between N_REQ sprite pixel requesters (player, enemies, projectiles, background).
- Round-robin arbitration grants at most one lookup per clock.
- The lookup runs in a 2-stage registered pipeline; the RGB result returns tagged with the requester ID plus a colour-key (transparent) flag.
- Sits between the per-sprite ROM address/index generators and the VGA colour mapper.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 3, width of requester ID fields; must satisfy 2^ID_W >= N_REQ.
- KEY_INDEX, 0, palette index treated as transparent (colour key).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester lookup request.
- req_index  in  N_REQ*4  packed 4-bit palette indices; requester i occupies bits [4i+3:4i].
- req_ready  out  N_REQ  one-hot grant, combinational; the request is accepted on a cycle where req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  result valid pulse.
- rsp_id  out  ID_W  requester that owns the result.
- rsp_red, rsp_green, rsp_blue  out  4 each  looked-up colour.
- rsp_transparent  out  1  high when the looked-up index equals KEY_INDEX.
- busy  out  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Palette contents, index 0..15, as RGB hex triples: F0D 302 A00 A09 BBB 500 776 000 504 D0B 200 862 432 700 C20 807.
- The palette is a fixed table inside this block.
- Arbitration:
  - rr_ptr (ID_W bits) marks the highest-priority requester.
  - Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - The first requester with req_valid high gets req_ready; all other ready bits stay low.
  - req_ready is all-zero when no request is valid.
  - After a grant to requester g, rr_ptr <= (g+1) mod N_REQ.
  - With no grant, rr_ptr holds its value.
- Pipeline:
  - Stage 1 registers {valid, id, index} of the granted request.
  - Stage 2 registers {valid, id, RGB, transparent}, with the palette read between the stages.
  - Outputs come directly from stage 2.
  - Latency: a grant at edge k drives rsp_valid high after edge k+2.
  - Throughput: one lookup per cycle.
  - There is no downstream backpressure; the pipeline always advances.
- rsp_valid is a single-cycle pulse per accepted request.
- When rsp_valid is low, rsp_id, RGB and rsp_transparent hold their last values.
- rsp_transparent = (index == KEY_INDEX). RGB is still output for a transparent index (F0D for index 0 at default).
- Reset:
  - All state clears: rr_ptr=0, both stage valids=0, rsp_valid=0, rsp_id=0, RGB=000, rsp_transparent=0, busy=0.
  - While Reset is high, req_ready is forced to 0.
  - A reset asserted mid-flight discards in-flight lookups; no response for them ever appears.
- Requests that are not granted must be held by the requester; this block keeps no queue.
- A requester may deassert req_valid without penalty while it is not granted.
- busy = stage1.valid | stage2.valid.

Test Plan:
- Reset, then only req 2 valid with index 4 every cycle:
  - req_ready = 0100 each cycle.
  - rsp_valid is first seen 2 cycles after the first grant, with rsp_id=2, RGB=BBB, rsp_transparent=0, and then stays high every cycle.
- All 4 requesters valid continuously with indices 1,2,3,4:
  - Grants rotate 0,1,2,3,0,...
  - Responses arrive in the same order: 302, A00, A09, BBB.
- Req 1 index 0 alone:
  - rsp_id=1, RGB=F0D, rsp_transparent=1.
- After a grant to req 3 (rr_ptr wraps to 0), raise req 0 and req 3 together:
  - req 0 is granted first; req 3 is granted on the next cycle.
- Grant req 1 (index 15); assert Reset on the following cycle for 1 cycle:
  - No rsp_valid for that lookup.
  - After reset, rr_ptr=0 and all outputs are zero.
  - Req 0 and req 1 both valid → req 0 is granted.
- Sweep indices 0..15 through req 0 back-to-back:
  - 16 consecutive rsp_valid pulses matching the palette table in order.
  - busy drops 2 cycles after the last grant.
